// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encodings and channel-wrap helper for mux_scan_nto1
package mux_scan_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAN  = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  function automatic int next_ch(input int ch, input int n);
    return (ch >= n - 1) ? 0 : ch + 1;
  endfunction
endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational NUM_CH x DATA_W mux; out-of-range selects give zero data
module mux_nto1 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [CH_W-1:0]          sel_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     in_range_o
);
  assign in_range_o = int'(sel_i) < NUM_CH;
  // pick the addressed channel, zero when no channel matches
  always_comb begin
    data_o = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(sel_i) == k) data_o = data_i[k*DATA_W +: DATA_W];
  end
endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 mux with manual/scan modes; MUX_SCAN_MASK_EN adds ch_mask_i
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 8,
  parameter int DWELL_W = 8,
  parameter int CH_W    = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic [CH_W-1:0]          sel_i,
  input  logic                     req_i,
  input  logic [DWELL_W-1:0]       dwell_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask_i,
`endif
  output logic [DATA_W-1:0]        out_data_o,
  output logic [CH_W-1:0]          out_ch_o,
  output logic                     out_valid_o,
  output logic                     out_err_o,
  input  logic                     out_ready_i
);
  logic [1:0]         state_q, state_d;
  logic [CH_W-1:0]    ptr_q, ptr_d, cap_ch, mux_sel, out_ch_q, out_ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d, mux_data;
  logic               out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic               mux_ok, man_ok, any_en, free, cap_man, cap_scan, scan_stay;
  logic [NUM_CH-1:0]  mask;
  int                 idx;

`ifdef MUX_SCAN_MASK_EN
  assign mask = ch_mask_i;
`else
  assign mask = '1;
`endif

  // find the first enabled channel at or after ptr, wrapping round
  always_comb begin
    cap_ch = ptr_q;
    any_en = 1'b0;
    idx    = int'(ptr_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_en && |(mask & (NUM_CH'(1) << idx))) begin
        cap_ch = CH_W'(idx);
        any_en = 1'b1;
      end
      idx = next_ch(idx, NUM_CH);
    end
  end

  assign mux_sel = (state_q == SCAN) ? cap_ch : sel_i;

  mux_nto1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) u_mux (
    .data_i     (data_i),
    .sel_i      (mux_sel),
    .data_o     (mux_data),
    .in_range_o (mux_ok)
  );

  assign free      = !out_valid_q || out_ready_i;
  assign man_ok    = mux_ok && |(mask & (NUM_CH'(1) << sel_i));
  assign scan_stay = state_q == SCAN && en_i && mode_i;
  assign cap_man   = state_q == MAN && en_i && !mode_i && req_i && free;
  assign cap_scan  = scan_stay && cnt_q == '0 && free && any_en;

  // state, scan pointer/dwell and output stage next values
  always_comb begin
    state_d     = !en_i ? IDLE :
                  state_q == IDLE ? (mode_i ? SCAN : MAN) :
                  (state_q == MAN && mode_i) || (state_q == SCAN && !mode_i) ? IDLE : state_q;
    ptr_d       = !scan_stay ? '0 : cap_scan ? CH_W'(next_ch(int'(cap_ch), NUM_CH)) : ptr_q;
    cnt_d       = !scan_stay ? '0 : cap_scan ? dwell_i : (cnt_q != '0) ? cnt_q - DWELL_W'(1) : cnt_q;
    out_data_d  = cap_man ? (man_ok ? mux_data : '0) : cap_scan ? mux_data : out_data_q;
    out_ch_d    = cap_man ? sel_i : cap_scan ? cap_ch : out_ch_q;
    out_err_d   = cap_man ? !man_ok : cap_scan ? 1'b0 : out_err_q;
    out_valid_d = (cap_man || cap_scan) ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
  end

  // register everything, async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign out_valid_o = out_valid_q;
  assign out_err_o   = out_err_q;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb_mux_scan_nto1: scoreboard bench for an 8-channel and a 6-channel mux_scan_nto1
module tb_mux_scan_nto1;
  typedef struct {
    logic [7:0] d;
    logic [2:0] c;
    logic       e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, en6, mode, req, req6, ready;
  logic [2:0] sel;
  logic [7:0] dwell, mask;
  logic [63:0] data8;
  logic [47:0] data6;
  logic [7:0] d8, d6;
  logic [2:0] c8, c6;
  logic       v8, v6, e8, e6;
  exp_t       q8[$], q6[$];
  exp_t       x8, x6;
  int         checks = 0, errors = 0, cyc = 0;
  int         ts[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_scan_nto1 #(.NUM_CH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .sel_i(sel), .req_i(req),
    .dwell_i(dwell), .data_i(data8),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask_i(mask),
`endif
    .out_data_o(d8), .out_ch_o(c8), .out_valid_o(v8), .out_err_o(e8), .out_ready_i(ready)
  );

  mux_scan_nto1 #(.NUM_CH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .en_i(en6), .mode_i(1'b0), .sel_i(sel), .req_i(req6),
    .dwell_i(dwell), .data_i(data6),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask_i(6'h3f),
`endif
    .out_data_o(d6), .out_ch_o(c6), .out_valid_o(v6), .out_err_o(e6), .out_ready_i(ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [2:0] c, input logic e);
    exp_t x;
    x.d = d;
    x.c = c;
    x.e = e;
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n && v8 && ready) begin
      if (q8.size() == 0) chk("u8_unexpected_sample", int'(c8), 99);
      else begin
        x8 = q8.pop_front();
        chk("u8_data", int'(d8), int'(x8.d));
        chk("u8_ch", int'(c8), int'(x8.c));
        chk("u8_err", int'(e8), int'(x8.e));
      end
    end
    if (rst_n && v6 && ready) begin
      if (q6.size() == 0) chk("u6_unexpected_sample", int'(c6), 99);
      else begin
        x6 = q6.pop_front();
        chk("u6_data", int'(d6), int'(x6.d));
        chk("u6_ch", int'(c6), int'(x6.c));
        chk("u6_err", int'(e6), int'(x6.e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!v8 && n < 20) begin
      step();
      n++;
    end
    if (!v8) chk("u8_valid_timeout", 0, 1);
    t = cyc;
  endtask

  task automatic man(input logic [2:0] s, input logic r8, input logic r6);
    sel = s;
    req = r8;
    req6 = r6;
    if (r8) q8.push_back(mk(8'hA0 + 8'(s), s, 1'b0));
    if (r6) q6.push_back(s < 3'd6 ? mk(8'hB0 + 8'(s), s, 1'b0) : mk(8'h00, s, 1'b1));
    step();
    req = 1'b0;
    req6 = 1'b0;
    if (r8) chk("u8_man_latency", int'(v8), 1);
    if (r6) chk("u6_man_latency", int'(v6), 1);
    step();
  endtask

  initial begin
    for (int k = 0; k < 8; k++) data8[k*8 +: 8] = 8'hA0 + 8'(k);
    for (int k = 0; k < 6; k++) data6[k*8 +: 8] = 8'hB0 + 8'(k);
    rst_n = 1'b0; en = 1'b0; en6 = 1'b0; mode = 1'b0; sel = '0; req = 1'b0; req6 = 1'b0;
    dwell = '0; ready = 1'b1; mask = '1;
    repeat (2) step();
    chk("rst_data", int'(d8), 0);
    chk("rst_ch", int'(c8), 0);
    chk("rst_valid", int'(v8), 0);
    chk("rst_err", int'(e8), 0);
    chk("rst_valid6", int'(v6), 0);
    rst_n = 1'b1; en = 1'b1; en6 = 1'b1;
    step();
    man(3'd5, 1'b1, 1'b1);
    man(3'd2, 1'b1, 1'b1);
    man(3'd7, 1'b1, 1'b1);
    man(3'd0, 1'b1, 1'b1);
    man(3'd6, 1'b1, 1'b1);
    ready = 1'b0;
    man(3'd3, 1'b1, 1'b0);
    sel = 3'd4;
    req = 1'b1;
    step();
    req = 1'b0;
    chk("drop_ch_held", int'(c8), 3);
    chk("drop_data_held", int'(d8), 8'hA3);
    ready = 1'b1;
    step();
    chk("drop_valid_clear", int'(v8), 0);
    dwell = 8'd2;
    mode = 1'b1;
    for (int k = 0; k < 8; k++) q8.push_back(mk(8'hA0 + 8'(k), 3'(k), 1'b0));
    q8.push_back(mk(8'hA0, 3'd0, 1'b0));
    for (int j = 0; j < 9; j++) begin
      wait_valid(ts[j]);
      if (j > 0) chk("scan_period", ts[j] - ts[j-1], 3);
      if (j < 8) step();
    end
    ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("stall_ch", int'(c8), 0);
      chk("stall_valid", int'(v8), 1);
    end
    chk("stall_data", int'(d8), 8'hA0);
    ready = 1'b1;
    for (int k = 1; k < 4; k++) q8.push_back(mk(8'hA0 + 8'(k), 3'(k), 1'b0));
    step();
    chk("resume_ch", int'(c8), 1);
    chk("resume_valid", int'(v8), 1);
    step();
    wait_valid(ts[0]);
    step();
    wait_valid(ts[0]);
    chk("pre_reset_ch", int'(c8), 3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", int'(d8), 0);
    chk("async_rst_ch", int'(c8), 0);
    chk("async_rst_valid", int'(v8), 0);
    chk("async_rst_err", int'(e8), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    q8.push_back(mk(8'hA0, 3'd0, 1'b0));
    q8.push_back(mk(8'hA1, 3'd1, 1'b0));
    step();
    wait_valid(ts[0]);
    chk("restart_ch", int'(c8), 0);
    step();
    wait_valid(ts[0]);
    en = 1'b0;
    step();
`ifdef MUX_SCAN_MASK_EN
    mask = 8'b1010_0010;
    en = 1'b1;
    q8.push_back(mk(8'hA1, 3'd1, 1'b0));
    q8.push_back(mk(8'hA5, 3'd5, 1'b0));
    q8.push_back(mk(8'hA7, 3'd7, 1'b0));
    q8.push_back(mk(8'hA1, 3'd1, 1'b0));
    for (int j = 0; j < 4; j++) begin
      wait_valid(ts[0]);
      if (j < 3) step();
    end
    en = 1'b0;
    step();
    mask = 8'h00;
    en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
      chk("mask_zero_valid", int'(v8), 0);
    end
    en = 1'b0;
`endif
    repeat (5) step();
    chk("q8_drained", q8.size(), 0);
    chk("q6_drained", q6.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
